// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg -- shared definitions for the Booth multiplier / MAC datapath.
//
// Contents
//   DEF_SIZE      default operand width of the upstream Booth multiplier
//   DEF_N_TERMS   default number of products folded into one result
//   ACC_GUARD     extra accumulator bits above the 2*SIZE product width
//   DEF_ACC_W     default accumulator width (2*DEF_SIZE + ACC_GUARD)
//   mac_state_t   MAC accumulator FSM state encoding
//   cnt_width()   width of a counter that must hold the value n
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int DEF_SIZE    = 4;
  localparam int DEF_N_TERMS = 4;
  localparam int ACC_GUARD   = 4;
  localparam int DEF_ACC_W   = 2*DEF_SIZE + ACC_GUARD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } mac_state_t;

  // The term counter must reach n itself without wrapping, so n+1 codes.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// -----------------------------------------------------------------------------
// mac_sat_add -- combinational saturating adder for the MAC accumulator.
//
// Adds a signed IN_W-bit term (sign-extended) to a signed ACC_W-bit running
// sum and clamps the result to the representable ACC_W-bit range.
// IN_W must not exceed ACC_W.
//
// Ports
//   i_acc   in   ACC_W  signed running sum
//   i_term  in   IN_W   signed term to add
//   o_sum   out  ACC_W  signed saturated sum
//   o_ovf   out  1      the exact sum did not fit and was clamped
// -----------------------------------------------------------------------------
module mac_sat_add #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 12
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [IN_W-1:0]  i_term,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_ovf
);

  // One extra bit is enough: the sum of an ACC_W-bit and an IN_W<=ACC_W-bit
  // signed value always fits in ACC_W+1 bits.
  localparam int EXT_W = ACC_W + 1;

  logic signed [EXT_W-1:0] w_acc_ext;
  logic signed [EXT_W-1:0] w_term_ext;
  logic signed [EXT_W-1:0] w_sum_ext;

  // The exact sum overflowed the ACC_W range iff its top two bits disagree.
  function automatic logic is_ovf(input logic signed [EXT_W-1:0] v);
    return v[EXT_W-1] ^ v[EXT_W-2];
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_to_acc(
    input logic signed [EXT_W-1:0] v
  );
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    max_v = {1'b0, {(ACC_W-1){1'b1}}};
    min_v = {1'b1, {(ACC_W-1){1'b0}}};
    if (is_ovf(v)) begin
      // The top bit of the exact sum carries the true sign.
      return v[EXT_W-1] ? min_v : max_v;
    end
    return v[ACC_W-1:0];
  endfunction

  assign w_acc_ext  = {i_acc[ACC_W-1], i_acc};
  assign w_term_ext = {{(EXT_W-IN_W){i_term[IN_W-1]}}, i_term};
  assign w_sum_ext  = w_acc_ext + w_term_ext;

  assign o_sum = sat_to_acc(w_sum_ext);
  assign o_ovf = is_ovf(w_sum_ext);

endmodule

// File: rtl/mac_accum.sv
// -----------------------------------------------------------------------------
// mac_accum -- dot-product accumulator behind a Booth multiplier.
//
// After start (accepted only in IDLE) the block takes N_TERMS signed products
// through a valid/ready handshake, sums them with saturation into an ACC_W-bit
// accumulator, then presents the result until the downstream accepts it.
//
//   IDLE  --start-->  ACCUM  --N_TERMS-th transfer-->  HOLD  --out_ready-->  IDLE
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous active-high reset
//   start      in   1       begin a new accumulation (IDLE only)
//   p_in       in   2*SIZE  signed product
//   p_valid    in   1       p_in is valid
//   p_ready    out  1       product accepted this cycle (ACCUM)
//   acc_out    out  ACC_W   signed accumulator value
//   out_valid  out  1       acc_out is a final result (HOLD)
//   out_ready  in   1       downstream takes the result
//   busy       out  1       FSM not in IDLE
//   ovf        out  1       sticky saturation flag of the current accumulation
// -----------------------------------------------------------------------------
module mac_accum
  import mult_pkg::*;
#(
  parameter int SIZE    = DEF_SIZE,
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int ACC_W   = 2*SIZE + ACC_GUARD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [2*SIZE-1:0] p_in,
  input  logic                    p_valid,
  output logic                    p_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    ovf
);

  localparam int P_W   = 2*SIZE;
  localparam int CNT_W = cnt_width(N_TERMS);
  // Count value seen on the transfer that completes the result.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

  mac_state_t              r_state;
  mac_state_t              w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf;

  logic signed [ACC_W-1:0] w_acc_sum;
  logic                    w_sum_ovf;
  logic                    w_xfer;
  logic                    w_start_acc;

  mac_sat_add #(
    .IN_W  (P_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .i_acc  (r_acc),
    .i_term (p_in),
    .o_sum  (w_acc_sum),
    .o_ovf  (w_sum_ovf)
  );

  // p_ready is exactly "state is ACCUM", so a transfer needs only p_valid.
  assign w_xfer      = (r_state == ST_ACCUM) && p_valid;
  assign w_start_acc = (r_state == ST_IDLE) && start;

  always_comb begin
    w_state_nxt = r_state;
    p_ready     = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        p_ready = 1'b1;
        if (p_valid && (r_cnt == LAST_IDX)) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The accumulator is cleared by reset as well: an aborted accumulation must
  // not leave a partial sum visible on acc_out.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_xfer) begin
      r_acc <= w_acc_sum;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_sum_ovf) r_ovf <= 1'b1;
    end
  end

  assign acc_out = r_acc;
  assign ovf     = r_ovf;

endmodule
